// File: rtl/morse_pkg.sv
// Shared Morse front-end definitions: FSM state encoding and default tick constants.
// Optional word-gap detection is enabled with MORSE_TIMER_WORD_GAP_EN.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_WGAP  = 2'd3
  } state_e;

  localparam int unsigned DEF_TICK_CYCLES    = 500000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 2;
  localparam int unsigned DEF_DOT_MAX_TICKS  = 20;
  localparam int unsigned DEF_CHAR_GAP_TICKS = 40;
  localparam int unsigned DEF_WORD_GAP_TICKS = 100;
  localparam int unsigned DEF_CNT_W          = 8;

endpackage

// File: rtl/morse_timer_if.sv
// Key-in / classified-pulse-out bundle between the key front end and the alphabet decoder.
// END_WORD exists only when MORSE_TIMER_WORD_GAP_EN is defined.
interface morse_timer_if;

  logic KEY;
  logic KEY_LVL;
  logic SHORT;
  logic LONG;
  logic END_CHAR;
`ifdef MORSE_TIMER_WORD_GAP_EN
  logic END_WORD;

  modport master (output KEY, input KEY_LVL, input SHORT, input LONG, input END_CHAR,
                  input END_WORD);
  modport slave  (input KEY, output KEY_LVL, output SHORT, output LONG, output END_CHAR,
                  output END_WORD);
`else
  modport master (output KEY, input KEY_LVL, input SHORT, input LONG, input END_CHAR);
  modport slave  (input KEY, output KEY_LVL, output SHORT, output LONG, output END_CHAR);
`endif

endinterface

// File: rtl/morse_debounce.sv
// Key synchronizer and tick-based debouncer; emits the accepted level and edge strobes.
module morse_debounce
  import morse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic key_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Mismatch counter: level flips once the synchronized key disagrees on enough ticks.
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
        cnt_d  = '0;
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
        fall_d = lvl_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/morse_timer.sv
// Morse key timing classifier: prescaled tick, debounced key, SHORT/LONG/END_CHAR pulses.
// Define MORSE_TIMER_WORD_GAP_EN to add the WGAP state and END_WORD pulse.
module morse_timer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned DOT_MAX_TICKS  = DEF_DOT_MAX_TICKS,
  parameter int unsigned CHAR_GAP_TICKS = DEF_CHAR_GAP_TICKS,
  parameter int unsigned WORD_GAP_TICKS = DEF_WORD_GAP_TICKS,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic          Clk,
  input  logic          RESET,
  morse_timer_if.slave  bus
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // Gap never has to count past the longest gap it times.
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(WORD_GAP_TICKS);
  localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_TICKS);
  localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(CHAR_GAP_TICKS);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_c;
  logic          lvl_c, rise_c, fall_c;

  state_e          state_q;
  logic [CNT_W-1:0] dur_q, gap_q;
  logic            short_q, long_q, endc_q;

  assign tick_c = (pre_q == PW'(TICK_CYCLES - 1));
  assign pre_d  = tick_c ? '0 : pre_q + PW'(1);

  always_ff @(posedge Clk) begin
    if (RESET) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  morse_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debounce (
    .clk_i  (Clk),
    .rst_i  (RESET),
    .tick_i (tick_c),
    .key_i  (bus.KEY),
    .lvl_o  (lvl_c),
    .rise_o (rise_c),
    .fall_o (fall_c)
  );

`ifdef MORSE_TIMER_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(WORD_GAP_TICKS);
  logic endw_q;
`endif

  // Classifier FSM; an edge strobe takes priority over a coincident tick.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      gap_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      endc_q  <= 1'b0;
`ifdef MORSE_TIMER_WORD_GAP_EN
      endw_q  <= 1'b0;
`endif
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      endc_q  <= 1'b0;
`ifdef MORSE_TIMER_WORD_GAP_EN
      endw_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_q <= ST_PRESS;
            dur_q   <= '0;
          end
        end
        ST_PRESS: begin
          if (fall_c) begin
            if (dur_q <= DOT_MAX) short_q <= 1'b1;
            else                  long_q  <= 1'b1;
            state_q <= ST_GAP;
            gap_q   <= '0;
          end else if (tick_c && (dur_q != '1)) begin
            dur_q <= dur_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (rise_c) begin
            state_q <= ST_PRESS;
            dur_q   <= '0;
          end else begin
            if (gap_q == CHAR_GAP) begin
              endc_q  <= 1'b1;
`ifdef MORSE_TIMER_WORD_GAP_EN
              state_q <= ST_WGAP;
`else
              state_q <= ST_IDLE;
`endif
            end
            if (tick_c && (gap_q != GAP_MAX)) gap_q <= gap_q + CNT_W'(1);
          end
        end
`ifdef MORSE_TIMER_WORD_GAP_EN
        ST_WGAP: begin
          if (rise_c) begin
            state_q <= ST_PRESS;
            dur_q   <= '0;
          end else begin
            if (gap_q == WORD_GAP) begin
              endw_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
            if (tick_c && (gap_q != GAP_MAX)) gap_q <= gap_q + CNT_W'(1);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.KEY_LVL  = lvl_c;
  assign bus.SHORT    = short_q;
  assign bus.LONG     = long_q;
  assign bus.END_CHAR = endc_q;
`ifdef MORSE_TIMER_WORD_GAP_EN
  assign bus.END_WORD = endw_q;
`endif

endmodule

// File: tb/tb_morse_timer.sv
// Directed bench for morse_timer with a 4-cycle tick; END_WORD checks follow MORSE_TIMER_WORD_GAP_EN.
module tb_morse_timer;

  logic Clk;
  logic RESET;
  morse_timer_if bus ();

  morse_timer #(
    .TICK_CYCLES    (4),
    .DEBOUNCE_TICKS (2),
    .DOT_MAX_TICKS  (3),
    .CHAR_GAP_TICKS (6),
    .WORD_GAP_TICKS (14),
    .CNT_W          (8)
  ) dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int errors = 0;

  // Clock edges since the last reset edge; tick edges leave cyc a multiple of 4.
  int cyc = 0;
  always @(posedge Clk) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_rise = 0, n_fall = 0, n_short = 0, n_long = 0, n_endc = 0, n_endw = 0;
  int rise_cyc = -1, fall_cyc = -1, short_cyc = -1, long_cyc = -1, endc_cyc = -1, endw_cyc = -1;
  int n_multi = 0, n_stretch = 0;
  logic p_lvl = 1'b0, p_short = 1'b0, p_long = 1'b0, p_endc = 1'b0, p_endw = 1'b0;

  // Event recorder, sampled on the falling edge.
  always @(negedge Clk) begin
    logic w;
`ifdef MORSE_TIMER_WORD_GAP_EN
    w = bus.END_WORD;
`else
    w = 1'b0;
`endif
    if (bus.KEY_LVL === 1'b1 && !p_lvl) begin n_rise++; rise_cyc = cyc; end
    if (bus.KEY_LVL === 1'b0 &&  p_lvl) begin n_fall++; fall_cyc = cyc; end
    if (bus.SHORT === 1'b1)    begin n_short++; short_cyc = cyc; end
    if (bus.LONG === 1'b1)     begin n_long++;  long_cyc  = cyc; end
    if (bus.END_CHAR === 1'b1) begin n_endc++;  endc_cyc  = cyc; end
    if (w === 1'b1)            begin n_endw++;  endw_cyc  = cyc; end
    if ((int'(bus.SHORT === 1'b1) + int'(bus.LONG === 1'b1) +
         int'(bus.END_CHAR === 1'b1) + int'(w === 1'b1)) > 1) n_multi++;
    if ((bus.SHORT === 1'b1 && p_short) || (bus.LONG === 1'b1 && p_long) ||
        (bus.END_CHAR === 1'b1 && p_endc) || (w === 1'b1 && p_endw)) n_stretch++;
    p_lvl   = (bus.KEY_LVL === 1'b1);
    p_short = (bus.SHORT === 1'b1);
    p_long  = (bus.LONG === 1'b1);
    p_endc  = (bus.END_CHAR === 1'b1);
    p_endw  = (w === 1'b1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic align();
    do @(negedge Clk); while (cyc % 4 != 0);
  endtask

  int c0, c1, c2, c3;
  int s_rise, s_short, s_long, s_endc, s_endw;

  task automatic snap();
    s_rise  = n_rise;
    s_short = n_short;
    s_long  = n_long;
    s_endc  = n_endc;
    s_endw  = n_endw;
  endtask

  initial begin
    RESET   = 1'b1;
    bus.KEY = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_key_lvl",  int'(bus.KEY_LVL),  0);
    check("rst_short",    int'(bus.SHORT),    0);
    check("rst_long",     int'(bus.LONG),     0);
    check("rst_end_char", int'(bus.END_CHAR), 0);
    RESET = 1'b0;
    repeat (8) @(negedge Clk);

    // Short press: 3 ticks held -> SHORT, END_CHAR 6 ticks later
    align(); snap(); c0 = cyc;
    bus.KEY = 1'b1; repeat (12) @(negedge Clk);
    bus.KEY = 1'b0; c1 = cyc;
    repeat (80) @(negedge Clk);
    check("t1_rise_cyc",  rise_cyc,  c0 + 8);
    check("t1_fall_cyc",  fall_cyc,  c1 + 8);
    check("t1_short_cyc", short_cyc, c1 + 9);
    check("t1_short_cnt", n_short - s_short, 1);
    check("t1_long_cnt",  n_long - s_long,   0);
    check("t1_endc_cyc",  endc_cyc,  c1 + 33);
    check("t1_endc_cnt",  n_endc - s_endc,   1);
`ifdef MORSE_TIMER_WORD_GAP_EN
    check("t1_endw_cyc",  endw_cyc,  c1 + 65);
    check("t1_endw_cnt",  n_endw - s_endw,   1);
`endif

    // Long press: 4 ticks held -> LONG
    align(); snap(); c0 = cyc;
    bus.KEY = 1'b1; repeat (16) @(negedge Clk);
    bus.KEY = 1'b0; c1 = cyc;
    repeat (80) @(negedge Clk);
    check("t2_long_cyc",  long_cyc, c1 + 9);
    check("t2_long_cnt",  n_long - s_long,   1);
    check("t2_short_cnt", n_short - s_short, 0);
    check("t2_endc_cyc",  endc_cyc, c1 + 33);

    // Character A: dot, 3-tick gap, dash
    align(); snap(); c0 = cyc;
    bus.KEY = 1'b1; repeat (12) @(negedge Clk);
    bus.KEY = 1'b0; repeat (12) @(negedge Clk);
    bus.KEY = 1'b1; c2 = cyc; repeat (16) @(negedge Clk);
    bus.KEY = 1'b0; c3 = cyc;
    repeat (80) @(negedge Clk);
    check("t3_short_cyc", short_cyc, c0 + 21);
    check("t3_long_cyc",  long_cyc,  c3 + 9);
    check("t3_short_cnt", n_short - s_short, 1);
    check("t3_long_cnt",  n_long - s_long,   1);
    check("t3_endc_cnt",  n_endc - s_endc,   1);
    check("t3_endc_cyc",  endc_cyc, c3 + 33);
    check("t3_second_rise", rise_cyc, c2 + 8);
`ifdef MORSE_TIMER_WORD_GAP_EN
    check("t3_endw_cnt",  n_endw - s_endw,   1);
`endif

    // Glitch of 5 clocks must be rejected
    align(); snap();
    bus.KEY = 1'b1; repeat (5) @(negedge Clk);
    bus.KEY = 1'b0; repeat (40) @(negedge Clk);
    check("t4_rise_cnt",  n_rise - s_rise, 0);
    check("t4_key_lvl",   int'(bus.KEY_LVL), 0);
    check("t4_pulse_cnt", (n_short - s_short) + (n_long - s_long) + (n_endc - s_endc), 0);

    // Reset during a held press; key re-accepted and timed afresh
    align(); snap();
    bus.KEY = 1'b1; repeat (12) @(negedge Clk);
    RESET = 1'b1; @(negedge Clk);
    check("t5_key_lvl",  int'(bus.KEY_LVL),  0);
    check("t5_short",    int'(bus.SHORT),    0);
    check("t5_long",     int'(bus.LONG),     0);
    check("t5_end_char", int'(bus.END_CHAR), 0);
    RESET = 1'b0;
    repeat (20) @(negedge Clk);
    bus.KEY = 1'b0;
    repeat (80) @(negedge Clk);
    check("t5_rise_cyc",  rise_cyc, 8);
    check("t5_long_cyc",  long_cyc, 29);
    check("t5_long_cnt",  n_long - s_long,   1);
    check("t5_short_cnt", n_short - s_short, 0);

    check("pulse_overlap", n_multi,   0);
    check("pulse_width",   n_stretch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
